if_stage: RTL

Instruction-fetch stage, directly upstream of the IF/ID pipeline register. It owns the PC and fetches each 32-bit instruction as four sequential byte reads over the shared 8-bit memory port, then assembles them little-endian. It presents the result as `if_pc`/`if_inst` to IF/ID, holds it while ID stalls, and restarts at `branch_target` on a branch interception. An all-zero `if_inst` is a bubble.

---
 rtl/if_stage_pkg.sv | 34 +++
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_icache.sv | 60 ++++++
 rtl/if_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg -- shared fetch-path types, constants and FSM encoding.
// Revision: 1.0
`default_nettype none

package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int BYTE_W      = 8;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [BYTE_W-1:0]      mem_byte_t;

  localparam inst_t ZERO_WORD = '0;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  localparam int ICACHE_LINES_DEF = 64;
  localparam int ICACHE_IDX_W_DEF = $clog2(ICACHE_LINES_DEF);
  typedef logic [ICACHE_IDX_W_DEF-1:0] icache_index_t;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_FETCH = 1'b0;
  localparam fsm_state_t ST_DONE  = 1'b1;

  // Tag width left after the word offset and the line index are removed.
  function automatic int icache_tag_w(input int lines);
    return INST_ADDR_W - $clog2(lines) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// if_stage_if -- redirect/stall controls, byte memory port and IF/ID outputs.
// Revision: 1.0
`default_nettype none

interface if_stage_if;
  import if_stage_pkg::*;

  logic       branch_interception;
  inst_addr_t branch_target;
  logic       id_stall;
  logic       mem_busy;
  mem_byte_t  mem_din;
  logic       mem_rd_en;
  inst_addr_t mem_addr;
  inst_addr_t if_pc;
  inst_t      if_inst;

  modport master (
    input  branch_interception, branch_target, id_stall, mem_busy, mem_din,
    output mem_rd_en, mem_addr, if_pc, if_inst
  );

  modport slave (
    output branch_interception, branch_target, id_stall, mem_busy, mem_din,
    input  mem_rd_en, mem_addr, if_pc, if_inst
  );

endinterface

`default_nettype wire

// File: rtl/if_stage_icache.sv
// if_stage_icache -- direct-mapped one-word-per-line instruction cache.
// Revision: 1.0
`default_nettype none

module if_stage_icache
  import if_stage_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  inst_addr_t i_lu_pc,
  output logic       o_lu_hit,
  output inst_t      o_lu_inst,
  input  logic       i_fill_we,
  input  inst_addr_t i_fill_pc,
  input  inst_t      i_fill_inst
);

  localparam int c_idx_w = $clog2(LINES);
  localparam int c_tag_w = icache_tag_w(LINES);

  logic [LINES-1:0]   r_valid;
  logic [c_tag_w-1:0] r_tag  [LINES];
  inst_t              r_data [LINES];

  logic [c_idx_w-1:0] w_lu_idx;
  logic [c_idx_w-1:0] w_fill_idx;
  logic [c_tag_w-1:0] w_lu_tag;
  logic [c_tag_w-1:0] w_fill_tag;
  logic               w_unused;

  assign w_lu_idx   = i_lu_pc[c_idx_w+1:2];
  assign w_lu_tag   = i_lu_pc[INST_ADDR_W-1:c_idx_w+2];
  assign w_fill_idx = i_fill_pc[c_idx_w+1:2];
  assign w_fill_tag = i_fill_pc[INST_ADDR_W-1:c_idx_w+2];
  assign w_unused   = &{1'b0, i_lu_pc[1:0], i_fill_pc[1:0]};

  assign o_lu_hit  = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
  assign o_lu_inst = r_data[w_lu_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_we) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_fill_inst;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage -- PC owner; fetches each word as four byte reads, presents it to IF/ID.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN. Revision: 1.0
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC     = 32'h0,
  parameter int         ICACHE_LINES = ICACHE_LINES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  fsm_state_t r_state, w_state_n;
  inst_addr_t r_pc, w_pc_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic       r_pending, w_pending_n;
  logic [1:0] r_lane, w_lane_n;
  logic [23:0] r_asm, w_asm_n;
  inst_addr_t r_if_pc, w_if_pc_n;
  inst_t      r_if_inst, w_if_inst_n;
  logic       r_rd_en, w_rd_en_n;
  inst_addr_t r_addr, w_addr_n;
  logic       r_hit, w_hit_n;
  inst_t      r_hit_inst;

  logic       w_accept;
  logic       w_cap3;
  inst_t      w_word;
  logic       w_lu_hit;
  inst_t      w_lu_inst;

  assign w_accept = r_rd_en & ~bus.mem_busy;
  assign w_cap3   = r_pending & (r_lane == 2'd3);
  assign w_word   = {bus.mem_din, r_asm};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (bus.branch_interception) begin
      w_state_n = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: if (w_cap3 || r_hit)   w_state_n = ST_DONE;
        ST_DONE:  if (!bus.id_stall)     w_state_n = ST_FETCH;
        default:                         w_state_n = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_n      = r_pc;
    w_cnt_n     = r_cnt;
    w_pending_n = FALSE;
    w_lane_n    = r_lane;
    w_asm_n     = r_asm;
    w_if_pc_n   = r_if_pc;
    w_if_inst_n = r_if_inst;
    if (bus.branch_interception) begin
      // Any byte still in flight is dropped by leaving pending clear.
      w_pc_n      = bus.branch_target;
      w_cnt_n     = 3'd0;
      w_if_pc_n   = ZERO_WORD;
      w_if_inst_n = ZERO_WORD;
    end else if (r_state == ST_FETCH) begin
      if (w_accept) begin
        w_cnt_n     = r_cnt + 3'd1;
        w_pending_n = TRUE;
        w_lane_n    = r_cnt[1:0];
      end
      if (r_pending) begin
        case (r_lane)
          2'd0:    w_asm_n[7:0]   = bus.mem_din;
          2'd1:    w_asm_n[15:8]  = bus.mem_din;
          2'd2:    w_asm_n[23:16] = bus.mem_din;
          default: w_asm_n        = r_asm;
        endcase
      end
      if (w_cap3) begin
        w_if_pc_n   = r_pc;
        w_if_inst_n = w_word;
      end else if (r_hit) begin
        w_if_pc_n   = r_pc;
        w_if_inst_n = r_hit_inst;
      end
    end else if (!bus.id_stall) begin
      w_pc_n      = r_pc + 32'd4;
      w_cnt_n     = 3'd0;
      w_if_pc_n   = ZERO_WORD;
      w_if_inst_n = ZERO_WORD;
    end
  end

  // The next request is decided one cycle ahead so the memory port is registered.
  always_comb begin
    w_hit_n   = (w_state_n == ST_FETCH) && (w_cnt_n == 3'd0) && w_lu_hit;
    w_rd_en_n = (w_state_n == ST_FETCH) && (w_cnt_n < 3'd4) && !w_hit_n;
    w_addr_n  = w_pc_n + {29'd0, w_cnt_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_cnt      <= 3'd0;
      r_pending  <= FALSE;
      r_lane     <= 2'd0;
      r_asm      <= '0;
      r_if_pc    <= ZERO_WORD;
      r_if_inst  <= ZERO_WORD;
      r_rd_en    <= FALSE;
      r_addr     <= '0;
      r_hit      <= FALSE;
      r_hit_inst <= ZERO_WORD;
    end else begin
      r_pc       <= w_pc_n;
      r_cnt      <= w_cnt_n;
      r_pending  <= w_pending_n;
      r_lane     <= w_lane_n;
      r_asm      <= w_asm_n;
      r_if_pc    <= w_if_pc_n;
      r_if_inst  <= w_if_inst_n;
      r_rd_en    <= w_rd_en_n;
      r_addr     <= w_addr_n;
      r_hit      <= w_hit_n;
      r_hit_inst <= w_lu_inst;
    end
  end

  assign bus.mem_rd_en = r_rd_en;
  assign bus.mem_addr  = r_addr;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_inst   = r_if_inst;

`ifdef ICACHE_EN
  logic w_fill_we;

  // A word overtaken by a redirect is not written into the cache.
  assign w_fill_we = w_cap3 & ~bus.branch_interception;

  if_stage_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .i_lu_pc     (w_pc_n),
    .o_lu_hit    (w_lu_hit),
    .o_lu_inst   (w_lu_inst),
    .i_fill_we   (w_fill_we),
    .i_fill_pc   (r_pc),
    .i_fill_inst (w_word)
  );
`else
  localparam int c_unused_icache_lines = ICACHE_LINES;

  assign w_lu_hit  = FALSE;
  assign w_lu_inst = ZERO_WORD;
`endif

endmodule

`default_nettype wire
